id_ex_stage: RTL and testbench

//  ID/EX pipeline stage of the RV32I core. It sits downstream of the register file and upstream of the ALU.
//  - Drives the register file read addresses.
//  - Registers the decoded instruction.
//  - Resolves operand values. Forwarding priority: MEM stage, then WB stage, then same-edge WB shadow, then register file.
//  - Detects load-use hazards and inserts one bubble.
//  - Handshake is valid/ready on both sides; flush kills the stage.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/id_ex_fwd_mux.sv | 31 +++
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core widths, decoded control bundle layout and write-back select encodings.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CTRL_W = 16;

  typedef enum logic [1:0] {
    WB_PC4 = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_e;

  // Opaque to ID/EX; the layout only matters to the ALU/branch/write-back consumers.
  typedef struct packed {
    logic [6:0] rsvd;
    logic [2:0] branch;
    wb_sel_e    wb_sel;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Operand resolver: x0, MEM forward, WB forward, same-edge WB shadow, then register file data.
module id_ex_fwd_mux
  import riscv_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            sh_v,
  input  logic [XLEN-1:0] sh_d,
  input  logic [XLEN-1:0] rf_rdata,
  output logic [XLEN-1:0] op
);

  always_comb begin
    op = rf_rdata;
    if (rs == '0) begin
      op = '0;
    end else if (mem_we && (mem_rd == rs)) begin
      op = mem_data;
    end else if (wb_we && (wb_rd == rs)) begin
      op = wb_data;
    end else if (sh_v) begin
      op = sh_d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble and valid/ready handshake.
// Optional ID_EX_PERF_EN adds saturating stall and bubble counters.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_re,
  input  logic              id_reg_we,
  output logic [RA_W-1:0]   rf_r1,
  output logic [RA_W-1:0]   rf_r2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              mem_we,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RA_W-1:0]   ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_re,
  output logic              ex_reg_we,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic            ex_adv;
  logic            load_use;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  ctrl_t           ex_ctrl_q;
  logic            sh1_v;
  logic            sh2_v;
  logic [XLEN-1:0] sh1_d;
  logic [XLEN-1:0] sh2_d;

  assign ex_adv   = !ex_valid || ex_ready;
  assign load_use = ex_valid && ex_mem_re && (ex_rd != '0) &&
                    ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
  assign id_ready = ex_adv && !load_use && !flush;

  // While stalled the register file keeps re-reading the held sources so rf data stays current.
  assign rf_r1 = ex_adv ? id_rs1 : ex_rs1;
  assign rf_r2 = ex_adv ? id_rs2 : ex_rs2;

  assign ex_ctrl = ex_ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_ctrl_q <= '0;
      ex_mem_re <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_adv) begin
      ex_valid  <= id_valid && id_ready;
      ex_pc     <= id_pc;
      ex_rd     <= id_rd;
      ex_imm    <= id_imm;
      ex_ctrl_q <= ctrl_t'(id_ctrl);
      ex_mem_re <= id_mem_re;
      ex_reg_we <= id_reg_we;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
    end
  end

  // The register file returns pre-write data when read and write hit the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1_v <= 1'b0;
      sh2_v <= 1'b0;
      sh1_d <= '0;
      sh2_d <= '0;
    end else begin
      sh1_v <= wb_we && (wb_rd != '0) && (wb_rd == rf_r1);
      sh2_v <= wb_we && (wb_rd != '0) && (wb_rd == rf_r2);
      sh1_d <= wb_data;
      sh2_d <= wb_data;
    end
  end

  id_ex_fwd_mux u_fwd1 (
    .rs       (ex_rs1),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .sh_v     (sh1_v),
    .sh_d     (sh1_d),
    .rf_rdata (rf_rdata1),
    .op       (ex_op1)
  );

  id_ex_fwd_mux u_fwd2 (
    .rs       (ex_rs2),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .sh_v     (sh2_v),
    .sh_d     (sh2_d),
    .rf_rdata (rf_rdata2),
    .op       (ex_op2)
  );

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (id_valid && !id_ready && !flush && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (id_valid && ex_adv && load_use && !flush && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against an architectural operand model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush, id_valid, id_ready;
  logic [XLEN-1:0]   id_pc, id_imm;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_re, id_reg_we;
  logic [RA_W-1:0]   rf_r1, rf_r2;
  logic [XLEN-1:0]   rf_rdata1 = '0, rf_rdata2 = '0;
  logic              mem_we, wb_we;
  logic [RA_W-1:0]   mem_rd, wb_rd;
  logic [XLEN-1:0]   mem_data, wb_data;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_op1, ex_op2;
  logic [RA_W-1:0]   ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_re, ex_reg_we;

  logic [XLEN-1:0]   regs [0:31];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_re(id_mem_re), .id_reg_we(id_reg_we),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_re(ex_mem_re),
    .ex_reg_we(ex_reg_we), .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  // Architectural value a source register should present right now.
  function automatic logic [XLEN-1:0] arch_val(input logic [RA_W-1:0] rs);
    if (rs == '0) return '0;
    if (mem_we && mem_rd == rs) return mem_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return regs[rs];
  endfunction

  task automatic idle();
    flush = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
    id_rd = '0; id_imm = '0; id_ctrl = '0; id_mem_re = 1'b0; id_reg_we = 1'b0;
    mem_we = 1'b0; mem_rd = '0; mem_data = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1,
                        input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
                        input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl,
                        input logic mre, input logic rwe);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_imm = imm; id_ctrl = ctrl; id_mem_re = mre; id_reg_we = rwe;
  endtask

  // One clock: registered-read register file that returns pre-write data on a same-edge write.
  task automatic tick();
    logic [RA_W-1:0] a1, a2;
    #1;
    a1 = rf_r1; a2 = rf_r2;
    @(posedge clk);
    rf_rdata1 = regs[a1];
    rf_rdata2 = regs[a2];
    if (wb_we && wb_rd != '0) regs[wb_rd] = wb_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); ex_ready = 1'b0;
    set_id(32'h100, 5'd1, 5'd2, 5'd9, 32'h55, 16'h1234, 1'b0, 1'b1);
    tick();
    set_id(32'h104, 5'd3, 5'd4, 5'd10, 32'h66, 16'h4321, 1'b0, 1'b1);
    tick();
    #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin
      tests_failed++; $display("FAIL reset_prestall valid=%b pc=%h expected 1/00000100", ex_valid, ex_pc);
    end
    rst_n = 1'b0; #1;
    tests_run++;
    if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_rd !== '0 || ex_imm !== '0 ||
        ex_ctrl !== '0 || ex_reg_we !== 1'b0 || ex_mem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async valid=%b pc=%h rd=%h imm=%h ctrl=%h expected all 0",
               ex_valid, ex_pc, ex_rd, ex_imm, ex_ctrl);
    end
    ex_ready = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_pc !== '0) begin
      tests_failed++; $display("FAIL reset_nocapture valid=%b pc=%h expected 0/0", ex_valid, ex_pc);
    end
    idle(); rst_n = 1'b1; #1;
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_op1 !== '0) begin
      tests_failed++;
      $display("FAIL reset_release valid=%b id_ready=%b op1=%h expected 0/1/0", ex_valid, id_ready, ex_op1);
    end
    tick();
  endtask

  task automatic test_mem_forward();
    idle(); regs[5] = '0;
    set_id(32'h200, 5'd5, 5'd9, 5'd6, 32'h0, 16'h0002, 1'b0, 1'b1);
    tick();
    idle(); ex_ready = 1'b0;
    mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234; #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_op1 !== 32'h1234) begin
      tests_failed++;
      $display("FAIL mem_fwd valid=%b rd=%h op1=%h expected 1/06/00001234", ex_valid, ex_rd, ex_op1);
    end
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555; #1;
    tests_run++;
    if (ex_op1 !== 32'h1234) begin
      tests_failed++; $display("FAIL mem_over_wb op1=%h expected 00001234", ex_op1);
    end
    mem_we = 1'b0; #1;
    tests_run++;
    if (ex_op1 !== 32'h5555) begin
      tests_failed++; $display("FAIL wb_fwd op1=%h expected 00005555", ex_op1);
    end
    wb_we = 1'b0; #1;
    tests_run++;
    if (ex_op1 !== 32'h0) begin
      tests_failed++; $display("FAIL rf_path op1=%h expected 00000000", ex_op1);
    end
    idle(); tick();
  endtask

  task automatic test_same_edge_wb();
    idle(); regs[7] = '0;
    set_id(32'h300, 5'd7, 5'd0, 5'd8, 32'h0, 16'h0001, 1'b0, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    tick();
    idle(); ex_ready = 1'b0; #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hDEAD || ex_op2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL same_edge_wb valid=%b op1=%h op2=%h expected 1/0000dead/0", ex_valid, ex_op1, ex_op2);
    end
    tick(); #1;
    tests_run++;
    if (ex_op1 !== 32'hDEAD) begin
      tests_failed++; $display("FAIL same_edge_reread op1=%h expected 0000dead", ex_op1);
    end
    idle(); tick();
  endtask

  task automatic test_load_use();
    idle(); regs[1] = 32'h11; regs[3] = 32'h0;
    set_id(32'h400, 5'd2, 5'd0, 5'd3, 32'h8, 16'h0020, 1'b1, 1'b1);
    tick();
    set_id(32'h404, 5'd3, 5'd1, 5'd4, 32'h0, 16'h0010, 1'b0, 1'b1); #1;
    tests_run++;
    if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_mem_re !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_stall id_ready=%b valid=%b mem_re=%b expected 0/1/1", id_ready, ex_valid, ex_mem_re);
    end
    tick(); #1;
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      tests_failed++; $display("FAIL load_use_bubble valid=%b id_ready=%b expected 0/1", ex_valid, id_ready);
    end
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE0003; #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_op1 !== 32'hCAFE0003 || ex_op2 !== 32'h11) begin
      tests_failed++;
      $display("FAIL load_use_accept valid=%b rd=%h op1=%h op2=%h expected 1/04/cafe0003/00000011",
               ex_valid, ex_rd, ex_op1, ex_op2);
    end
    tick();
    wb_we = 1'b0; #1;
    tests_run++;
    if (ex_op1 !== 32'hCAFE0003) begin
      tests_failed++; $display("FAIL load_use_shadow op1=%h expected cafe0003", ex_op1);
    end
    idle(); tick();
  endtask

  task automatic test_backpressure();
    idle(); regs[10] = 32'hA0; regs[11] = 32'hB0;
    set_id(32'h500, 5'd10, 5'd11, 5'd12, 32'h77, 16'h0001, 1'b0, 1'b1);
    tick();
    set_id(32'h504, 5'd13, 5'd14, 5'd15, 32'h88, 16'h0002, 1'b0, 1'b1);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_we = (i == 1); wb_rd = 5'd10; wb_data = 32'hBEEF; #1;
      tests_run++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || ex_imm !== 32'h77 || rf_r1 !== 5'd10 ||
          id_ready !== 1'b0 || ex_op1 !== ((i == 0) ? 32'hA0 : 32'hBEEF) || ex_op2 !== 32'hB0) begin
        tests_failed++;
        $display("FAIL backpressure_%0d valid=%b pc=%h imm=%h rf_r1=%h id_ready=%b op1=%h op2=%h",
                 i, ex_valid, ex_pc, ex_imm, rf_r1, id_ready, ex_op1, ex_op2);
      end
      tick();
    end
    wb_we = 1'b0; ex_ready = 1'b1; #1;
    tests_run++;
    if (ex_op1 !== 32'hBEEF || id_ready !== 1'b1 || rf_r1 !== 5'd13) begin
      tests_failed++;
      $display("FAIL backpressure_release op1=%h id_ready=%b rf_r1=%h expected 0000beef/1/0d",
               ex_op1, id_ready, rf_r1);
    end
    tick(); #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || ex_rd !== 5'd15) begin
      tests_failed++; $display("FAIL backpressure_next valid=%b pc=%h rd=%h expected 1/00000504/0f", ex_valid, ex_pc, ex_rd);
    end
    idle(); tick();
  endtask

  task automatic test_flush_x0();
    idle();
    set_id(32'h600, 5'd0, 5'd0, 5'd3, 32'h0, 16'h0020, 1'b1, 1'b1);
    tick();
    set_id(32'h604, 5'd3, 5'd0, 5'd4, 32'h0, 16'h0010, 1'b0, 1'b1);
    flush = 1'b1; #1;
    tests_run++;
    if (id_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_ready id_ready=%b expected 0", id_ready);
    end
    tick(); #1;
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_loaduse valid=%b expected 0", ex_valid);
    end
    idle();
    set_id(32'h700, 5'd1, 5'd2, 5'd5, 32'h0, 16'h0001, 1'b0, 1'b1);
    tick();
    ex_ready = 1'b0; id_pc = 32'h704;
    tick();
    flush = 1'b1;
    tick(); #1;
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stall valid=%b expected 0", ex_valid);
    end
    idle();
    set_id(32'h800, 5'd0, 5'd0, 5'd9, 32'h0, 16'h0001, 1'b0, 1'b1);
    tick();
    idle(); ex_ready = 1'b0;
    mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1357_9BDF; #1;
    tests_run++;
    if (ex_valid !== 1'b1 || ex_op1 !== '0 || ex_op2 !== '0) begin
      tests_failed++; $display("FAIL x0_operand valid=%b op1=%h op2=%h expected 1/0/0", ex_valid, ex_op1, ex_op2);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    logic            m_valid, m_mem_re, m_reg_we;
    logic [XLEN-1:0] m_pc, m_imm;
    logic [RA_W-1:0] m_rd, m_rs1, m_rs2;
    logic [CTRL_W-1:0] m_ctrl;
    logic            e_adv, e_lu, e_ready;
    idle(); flush = 1'b1;
    tick();
    m_valid = 1'b0; m_mem_re = 1'b0; m_reg_we = 1'b0; m_pc = '0; m_imm = '0;
    m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ctrl = '0;
    for (int n = 0; n < 600; n++) begin
      flush     = ($urandom_range(0, 9) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_pc     = $urandom;
      id_rs1    = RA_W'($urandom_range(0, 7));
      id_rs2    = RA_W'($urandom_range(0, 7));
      id_rd     = RA_W'($urandom_range(0, 7));
      id_imm    = $urandom;
      id_ctrl   = CTRL_W'($urandom);
      id_mem_re = ($urandom_range(0, 2) == 0);
      id_reg_we = ($urandom_range(0, 1) == 1);
      ex_ready  = ($urandom_range(0, 2) != 0);
      mem_we    = ($urandom_range(0, 2) == 0);
      mem_rd    = RA_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_rd     = RA_W'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      e_adv   = !m_valid || ex_ready;
      e_lu    = m_valid && m_mem_re && (m_rd != '0) && (id_rs1 == m_rd || id_rs2 == m_rd);
      e_ready = e_adv && !e_lu && !flush;
      tests_run++;
      if (id_ready !== e_ready || ex_valid !== m_valid ||
          rf_r1 !== (e_adv ? id_rs1 : m_rs1) || rf_r2 !== (e_adv ? id_rs2 : m_rs2)) begin
        tests_failed++;
        $display("FAIL rand_ctl_%0d id_ready=%b/%b valid=%b/%b rf_r1=%h rf_r2=%h",
                 n, id_ready, e_ready, ex_valid, m_valid, rf_r1, rf_r2);
      end
      if (m_valid) begin
        tests_run++;
        if (ex_pc !== m_pc || ex_rd !== m_rd || ex_imm !== m_imm || ex_ctrl !== m_ctrl ||
            ex_mem_re !== m_mem_re || ex_reg_we !== m_reg_we ||
            ex_op1 !== arch_val(m_rs1) || ex_op2 !== arch_val(m_rs2)) begin
          tests_failed++;
          $display("FAIL rand_data_%0d pc=%h/%h rd=%h/%h op1=%h/%h op2=%h/%h",
                   n, ex_pc, m_pc, ex_rd, m_rd, ex_op1, arch_val(m_rs1), ex_op2, arch_val(m_rs2));
        end
      end
      if (flush) begin
        m_valid = 1'b0;
      end else if (e_adv) begin
        m_valid = id_valid && e_ready; m_pc = id_pc; m_rd = id_rd; m_imm = id_imm;
        m_ctrl = id_ctrl; m_mem_re = id_mem_re; m_reg_we = id_reg_we;
        m_rs1 = id_rs1; m_rs2 = id_rs2;
      end
      tick();
    end
    idle(); tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = '0;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_mem_forward();
    test_same_edge_wb();
    test_load_use();
    test_backpressure();
    test_flush_x0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
